// File: rtl/regfile_read_arbiter.sv
// Shares one register-file read port between NUM_REQ requesters with a 1-cycle registered response.
// Optional build macro RFARB_FIXED_PRIORITY_EN selects fixed lowest-index priority instead of round-robin.
module regfile_read_arbiter #(
    parameter int unsigned NUM_REQ    = 4,
    parameter int unsigned DATA_WIDTH = 64,
    parameter int unsigned REG_COUNT  = 32,
    parameter int unsigned ADDR_WIDTH = $clog2(REG_COUNT),
    parameter int unsigned ZERO_REG   = 1
) (
    input  logic                          clk_i,
    input  logic                          reset_i,
    input  logic [NUM_REQ-1:0]            req_valid_i,
    input  logic [NUM_REQ*ADDR_WIDTH-1:0] req_addr_i,
    output logic [NUM_REQ-1:0]            req_ready_o,
    output logic [ADDR_WIDTH-1:0]         mux_select_o,
    input  logic [DATA_WIDTH-1:0]         mux_data_i,
    output logic [NUM_REQ-1:0]            rsp_valid_o,
    output logic [DATA_WIDTH-1:0]         rsp_data_o,
    output logic                          busy_o
);

    localparam int unsigned PTR_W = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
    localparam logic [ADDR_WIDTH-1:0] ZERO_ADDR = ADDR_WIDTH'(REG_COUNT - 1);
    localparam logic [PTR_W-1:0]      LAST_IDX  = PTR_W'(NUM_REQ - 1);

    logic [PTR_W-1:0] grant_idx;
    logic             grant_any;
    logic             zero_hit;

`ifdef RFARB_FIXED_PRIORITY_EN
    // Fixed priority: lowest valid index wins.
    always_comb begin
        grant_idx = '0;
        grant_any = 1'b0;
        for (int unsigned i = 0; i < NUM_REQ; i++) begin
            if (!grant_any && req_valid_i[i]) begin
                grant_idx = PTR_W'(i);
                grant_any = 1'b1;
            end
        end
    end
`else
    logic [PTR_W-1:0] rr_ptr;
    logic [PTR_W-1:0] scan_idx;

    // Round-robin: scan from rr_ptr, wrapping modulo NUM_REQ; first valid wins.
    always_comb begin
        grant_idx = '0;
        grant_any = 1'b0;
        scan_idx  = '0;
        for (int unsigned i = 0; i < NUM_REQ; i++) begin
            scan_idx = PTR_W'((32'(rr_ptr) + i) % NUM_REQ);
            if (!grant_any && req_valid_i[scan_idx]) begin
                grant_idx = scan_idx;
                grant_any = 1'b1;
            end
        end
    end

    // Pointer moves just past the winner only when a transfer happens.
    always_ff @(posedge clk_i) begin
        if (reset_i) begin
            rr_ptr <= '0;
        end else if (grant_any) begin
            rr_ptr <= (grant_idx == LAST_IDX) ? '0 : grant_idx + PTR_W'(1);
        end
    end
`endif

    // Grant and mux select are suppressed while reset is asserted.
    always_comb begin
        req_ready_o  = '0;
        mux_select_o = '0;
        if (grant_any && !reset_i) begin
            req_ready_o[grant_idx] = 1'b1;
            mux_select_o = req_addr_i[32'(grant_idx)*ADDR_WIDTH +: ADDR_WIDTH];
        end
    end

    assign zero_hit = (ZERO_REG != 0) && (mux_select_o == ZERO_ADDR);

    // Response register: data only updates on a transfer, otherwise holds.
    always_ff @(posedge clk_i) begin
        if (reset_i) begin
            rsp_valid_o <= '0;
            rsp_data_o  <= '0;
            busy_o      <= 1'b0;
        end else begin
            rsp_valid_o <= req_ready_o;
            busy_o      <= |req_ready_o;
            if (|req_ready_o) begin
                rsp_data_o <= zero_hit ? '0 : mux_data_i;
            end
        end
    end

endmodule

// File: tb/tb_regfile_read_arbiter.sv
// Directed self-checking bench for regfile_read_arbiter; a second instance covers ZERO_REG=0.
module tb_regfile_read_arbiter;

    localparam int unsigned NR = 4;
    localparam int unsigned DW = 64;
    localparam int unsigned AW = 5;

    logic          clk = 1'b0;
    logic          reset = 1'b0;
    logic [NR-1:0] req_valid = '0;
    logic [NR*AW-1:0] req_addr = '0;
    logic          mux_override = 1'b0;
    logic [DW-1:0] override_val = '0;

    logic [NR-1:0] req_ready, rsp_valid;
    logic [AW-1:0] mux_select;
    logic [DW-1:0] mux_data, rsp_data;
    logic          busy;

    logic [NR-1:0] nz_ready, nz_rsp_valid;
    logic [AW-1:0] nz_select;
    logic [DW-1:0] nz_mux_data, nz_rsp_data;
    logic          nz_busy;

    int tests = 0;
    int fails = 0;

    always #5 clk = ~clk;

    // Read-mux model: recognisable pattern carrying the select value.
    assign mux_data    = mux_override ? override_val : {32'hDEAD_BEEF, 27'd0, mux_select};
    assign nz_mux_data = mux_override ? override_val : {32'hDEAD_BEEF, 27'd0, nz_select};

    regfile_read_arbiter #(.NUM_REQ(NR), .DATA_WIDTH(DW), .REG_COUNT(32), .ADDR_WIDTH(AW), .ZERO_REG(1)) dut (
        .clk_i(clk), .reset_i(reset), .req_valid_i(req_valid), .req_addr_i(req_addr),
        .req_ready_o(req_ready), .mux_select_o(mux_select), .mux_data_i(mux_data),
        .rsp_valid_o(rsp_valid), .rsp_data_o(rsp_data), .busy_o(busy)
    );

    regfile_read_arbiter #(.NUM_REQ(NR), .DATA_WIDTH(DW), .REG_COUNT(32), .ADDR_WIDTH(AW), .ZERO_REG(0)) dut_nz (
        .clk_i(clk), .reset_i(reset), .req_valid_i(req_valid), .req_addr_i(req_addr),
        .req_ready_o(nz_ready), .mux_select_o(nz_select), .mux_data_i(nz_mux_data),
        .rsp_valid_o(nz_rsp_valid), .rsp_data_o(nz_rsp_data), .busy_o(nz_busy)
    );

    task automatic next_cycle();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        reset = 1'b1;
        req_valid = '0;
        next_cycle();
        reset = 1'b0;
    endtask

    task automatic test_reset();
        reset = 1'b1;
        req_valid = 4'b1111;
        for (int c = 0; c < 2; c++) begin
            #1;
            tests++;
            if (req_ready !== 4'b0000) begin
                fails++; $display("FAIL reset_ready c%0d: got %b want 0000", c, req_ready);
            end
            next_cycle();
            tests++;
            if (rsp_valid !== 4'b0000 || rsp_data !== 64'd0 || busy !== 1'b0) begin
                fails++;
                $display("FAIL reset_regs c%0d: got v=%b d=%h b=%b want v=0000 d=0 b=0", c, rsp_valid, rsp_data, busy);
            end
        end
        reset = 1'b0;
        req_valid = '0;
    endtask

    task automatic test_single();
        req_valid = 4'b0100;
        req_addr[2*AW +: AW] = 5'd5;
        #1;
        tests++;
        if (req_ready !== 4'b0100 || mux_select !== 5'd5) begin
            fails++; $display("FAIL single_grant: got rdy=%b sel=%0d want rdy=0100 sel=5", req_ready, mux_select);
        end
        next_cycle();
        req_valid = '0;
        tests++;
        if (rsp_valid !== 4'b0100 || rsp_data !== 64'hDEAD_BEEF_0000_0005 || busy !== 1'b1) begin
            fails++;
            $display("FAIL single_rsp: got v=%b d=%h b=%b want v=0100 d=deadbeef00000005 b=1", rsp_valid, rsp_data, busy);
        end
    endtask

    task automatic test_idle();
        #1;
        tests++;
        if (req_ready !== 4'b0000 || mux_select !== 5'd0) begin
            fails++; $display("FAIL idle_grant: got rdy=%b sel=%0d want rdy=0000 sel=0", req_ready, mux_select);
        end
        next_cycle();
        tests++;
        if (rsp_valid !== 4'b0000 || rsp_data !== 64'hDEAD_BEEF_0000_0005 || busy !== 1'b0) begin
            fails++;
            $display("FAIL idle_hold: got v=%b d=%h b=%b want v=0000 d=deadbeef00000005 b=0", rsp_valid, rsp_data, busy);
        end
    endtask

    task automatic test_round_robin();
        int exp_order[6];
`ifdef RFARB_FIXED_PRIORITY_EN
        exp_order = '{0, 0, 0, 0, 0, 0};
`else
        exp_order = '{0, 1, 2, 3, 0, 1};
`endif
        do_reset();
        for (int k = 0; k < NR; k++) req_addr[k*AW +: AW] = AW'(10 + k);
        req_valid = 4'b1111;
        for (int c = 0; c < 6; c++) begin
            logic [NR-1:0] exp_oh;
            logic [DW-1:0] exp_d;
            exp_oh = NR'(1) << exp_order[c];
            exp_d  = {32'hDEAD_BEEF, 27'd0, 5'(10 + exp_order[c])};
            #1;
            tests++;
            if (req_ready !== exp_oh) begin
                fails++; $display("FAIL rr_grant c%0d: got %b want %b", c, req_ready, exp_oh);
            end
            next_cycle();
            tests++;
            if (rsp_valid !== exp_oh || rsp_data !== exp_d || busy !== 1'b1) begin
                fails++;
                $display("FAIL rr_rsp c%0d: got v=%b d=%h b=%b want v=%b d=%h b=1", c, rsp_valid, rsp_data, busy, exp_oh, exp_d);
            end
        end
        req_valid = '0;
    endtask

    task automatic test_zero_reg();
        req_valid = 4'b0010;
        req_addr[1*AW +: AW] = 5'd31;
        mux_override = 1'b1;
        override_val = 64'hFFFF_FFFF_FFFF_FFFF;
        next_cycle();
        req_valid = '0;
        tests++;
        if (rsp_valid !== 4'b0010 || rsp_data !== 64'd0) begin
            fails++; $display("FAIL zero_reg_on: got v=%b d=%h want v=0010 d=0", rsp_valid, rsp_data);
        end
        tests++;
        if (nz_rsp_valid !== 4'b0010 || nz_rsp_data !== 64'hFFFF_FFFF_FFFF_FFFF) begin
            fails++; $display("FAIL zero_reg_off: got v=%b d=%h want v=0010 d=ffffffffffffffff", nz_rsp_valid, nz_rsp_data);
        end
        mux_override = 1'b0;
    endtask

    task automatic test_reset_inflight();
        do_reset();
        req_valid = 4'b1000;
        req_addr[3*AW +: AW] = 5'd7;
        next_cycle();
        reset = 1'b1;
        req_valid = 4'b1111;
        #1;
        tests++;
        if (req_ready !== 4'b0000) begin
            fails++; $display("FAIL inflight_ready: got %b want 0000", req_ready);
        end
        next_cycle();
        tests++;
        if (rsp_valid !== 4'b0000 || rsp_data !== 64'd0 || busy !== 1'b0) begin
            fails++;
            $display("FAIL inflight_drop: got v=%b d=%h b=%b want v=0000 d=0 b=0", rsp_valid, rsp_data, busy);
        end
        reset = 1'b0;
        #1;
        tests++;
        if (req_ready !== 4'b0001) begin
            fails++; $display("FAIL post_reset_grant: got %b want 0001", req_ready);
        end
    endtask

    task automatic test_priority();
        int exp_order[3];
`ifdef RFARB_FIXED_PRIORITY_EN
        exp_order = '{0, 0, 0};
`else
        exp_order = '{0, 3, 0};
`endif
        do_reset();
        req_valid = 4'b1001;
        for (int c = 0; c < 3; c++) begin
            logic [NR-1:0] exp_oh;
            exp_oh = NR'(1) << exp_order[c];
            #1;
            tests++;
            if (req_ready !== exp_oh) begin
                fails++; $display("FAIL prio_grant c%0d: got %b want %b", c, req_ready, exp_oh);
            end
            next_cycle();
        end
        req_valid = '0;
    endtask

    initial begin
        next_cycle();
        test_reset();
        test_single();
        test_idle();
        test_round_robin();
        test_zero_reg();
        test_reset_inflight();
        test_priority();
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
